// File: rtl/vga_scan_initiator_if.sv
// Pixel responder handshake and VGA output bundle for the scan initiator.
// master: the raster generator; slave: responder and display side.
interface vga_scan_initiator_if;
  logic [9:0] pixel_row;
  logic [9:0] pixel_column;
  logic [7:0] world_pixel;
  logic [3:0] red;
  logic [3:0] green;
  logic [3:0] blue;
  logic       horiz_sync;
  logic       vert_sync;
  logic       video_on;
  logic       frame_tick;

  modport master (
    output pixel_row, pixel_column, red, green, blue,
           horiz_sync, vert_sync, video_on, frame_tick,
    input  world_pixel
  );

  modport slave (
    input  pixel_row, pixel_column, red, green, blue,
           horiz_sync, vert_sync, video_on, frame_tick,
    output world_pixel
  );
endinterface

// File: rtl/vga_scan_initiator.sv
// VGA raster generator: requests pixels from the responder, samples them at the
// end of each slot and presents colour plus syncs one slot after the address.
module vga_scan_initiator #(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic                  clk,
  input  logic                  reset,
  vga_scan_initiator_if.master  vga
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] V_TICK   = 10'(V_DISPLAY - 1);
  localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [DIV_W-1:0] div;
  logic [9:0]       h_count;
  logic [9:0]       v_count;
  logic [9:0]       h_next;
  logic [9:0]       v_next;
  logic             slot_end;
  logic             visible;
  logic             hs_next;
  logic             vs_next;
  logic             tick_next;
  logic [3:0]       red_next;
  logic [3:0]       green_next;
  logic [3:0]       blue_next;

  logic [3:0]       red_q;
  logic [3:0]       green_q;
  logic [3:0]       blue_q;
  logic             hs_q;
  logic             vs_q;
  logic             video_on_q;
  logic             frame_tick_q;

  always_comb begin
    slot_end = (div == DIV_LAST);
    h_next   = h_count + 10'd1;
    v_next   = v_count;
    if (h_count == H_LAST) begin
      h_next = '0;
      v_next = (v_count == V_LAST) ? '0 : v_count + 10'd1;
    end
  end

  // Everything below decodes the address currently on the bus, which is the
  // one whose world_pixel is captured at this slot's closing edge.
  always_comb begin
    visible    = (h_count < H_VIS) && (v_count < V_VIS);
    hs_next    = !((h_count >= HS_FIRST) && (h_count <= HS_LAST));
    vs_next    = !((v_count >= VS_FIRST) && (v_count <= VS_LAST));
    tick_next  = (h_count == H_LAST) && (v_count == V_TICK);
    red_next   = '0;
    green_next = '0;
    blue_next  = '0;
    if (visible) begin
      red_next   = {vga.world_pixel[7:5], vga.world_pixel[7]};
      green_next = {vga.world_pixel[4:2], vga.world_pixel[4]};
      blue_next  = {vga.world_pixel[1:0], vga.world_pixel[1:0]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div          <= '0;
      h_count      <= '0;
      v_count      <= '0;
      red_q        <= '0;
      green_q      <= '0;
      blue_q       <= '0;
      hs_q         <= 1'b1;
      vs_q         <= 1'b1;
      video_on_q   <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      div          <= slot_end ? '0 : div + 1'b1;
      frame_tick_q <= 1'b0;
      if (slot_end) begin
        h_count      <= h_next;
        v_count      <= v_next;
        red_q        <= red_next;
        green_q      <= green_next;
        blue_q       <= blue_next;
        hs_q         <= hs_next;
        vs_q         <= vs_next;
        video_on_q   <= visible;
        frame_tick_q <= tick_next;
      end
    end
  end

  assign vga.pixel_row    = v_count;
  assign vga.pixel_column = h_count;
  assign vga.red          = red_q;
  assign vga.green        = green_q;
  assign vga.blue         = blue_q;
  assign vga.horiz_sync   = hs_q;
  assign vga.vert_sync    = vs_q;
  assign vga.video_on     = video_on_q;
  assign vga.frame_tick   = frame_tick_q;

endmodule

// File: tb/tb_vga_scan_initiator.sv
// Directed bench: full-size raster for line timing, colour and latency, plus a
// shrunken raster so frame-level timing fits in a short run.
module tb_vga_scan_initiator;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vga_scan_initiator_if ifa ();
  vga_scan_initiator_if ifs ();

  vga_scan_initiator dut (.clk(clk), .reset(reset), .vga(ifa));

  vga_scan_initiator #(
    .CLK_DIV(4), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_DISPLAY(4), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
  ) dut_s (.clk(clk), .reset(reset), .vga(ifs));

  int checks = 0;
  int errors = 0;
  int cyc;

  logic [7:0] wp_const;
  logic       lat_mode;
  logic [9:0] d1, d2, d3;

  function automatic logic [7:0] resp_f(input logic [9:0] col);
    return col[7:0] ^ 8'h5A;
  endfunction

  function automatic logic [11:0] map_rgb(input logic [7:0] w);
    return {w[7:5], w[7], w[4:2], w[4], w[1:0], w[1:0]};
  endfunction

  // Responder with three clocks of latency after each address change.
  always @(posedge clk) begin
    d1 <= ifa.pixel_column;
    d2 <= d1;
    d3 <= d2;
  end
  assign ifa.world_pixel = lat_mode ? resp_f(d3) : wp_const;
  assign ifs.world_pixel = 8'hFF;

  always @(posedge clk or posedge reset)
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;

  typedef struct {
    logic [7:0] wp;
    logic [9:0] col;
    logic [3:0] r, g, b;
    logic       von, hs;
  } vec_t;
  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_col(input logic [9:0] col);
    int n = 0;
    while (!(ifa.pixel_column == col && (cyc % 4) == 0) && n < 4000) begin
      step();
      n++;
    end
    if (n >= 4000) timeout("wait_col");
  endtask

  task automatic wait_hs(input logic lvl, output int t);
    int n = 0;
    logic prev;
    t = 0;
    forever begin
      prev = ifa.horiz_sync;
      step();
      n++;
      if (ifa.horiz_sync == lvl && prev != lvl) begin t = cyc; break; end
      if (n >= 4000) begin timeout("wait_hsync"); break; end
    end
  endtask

  task automatic wait_vs_s(input logic lvl, output int t);
    int n = 0;
    logic prev;
    t = 0;
    forever begin
      prev = ifs.vert_sync;
      step();
      n++;
      if (ifs.vert_sync == lvl && prev != lvl) begin t = cyc; break; end
      if (n >= 2000) begin timeout("wait_vsync"); break; end
    end
  endtask

  task automatic wait_tick_s(output int t);
    int n = 0;
    logic [9:0] prev_row;
    t = 0;
    forever begin
      prev_row = ifs.pixel_row;
      step();
      n++;
      if (ifs.frame_tick) begin
        t = cyc;
        chk("tick_row_after", ifs.pixel_row, 10'd4);
        chk("tick_row_before", prev_row, 10'd3);
        chk("tick_col", ifs.pixel_column, 10'd0);
        break;
      end
      if (n >= 2000) begin timeout("wait_frame_tick"); break; end
    end
  endtask

  task automatic wait_pos_s(input logic [9:0] row, input logic [9:0] col);
    int n = 0;
    while (!(ifs.pixel_row == row && ifs.pixel_column == col && (cyc % 4) == 0) && n < 2000) begin
      step();
      n++;
    end
    if (n >= 2000) timeout("wait_pos_small");
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_row"}, ifa.pixel_row, 10'd0);
    chk({tag, "_col"}, ifa.pixel_column, 10'd0);
    chk({tag, "_rgb"}, {ifa.red, ifa.green, ifa.blue}, 12'h000);
    chk({tag, "_von"}, ifa.video_on, 1'b0);
    chk({tag, "_tick"}, ifa.frame_tick, 1'b0);
    chk({tag, "_hsync"}, ifa.horiz_sync, 1'b1);
    chk({tag, "_vsync"}, ifa.vert_sync, 1'b1);
  endtask

  // After release with world_pixel = FF: column k/4, white from the 4th edge.
  task automatic check_startup(input string tag);
    for (int k = 1; k <= 12; k++) begin
      step();
      chk({tag, "_col"}, ifa.pixel_column, 10'(k / 4));
      chk({tag, "_row"}, ifa.pixel_row, 10'd0);
      chk({tag, "_rgbv"}, {ifa.red, ifa.green, ifa.blue, ifa.video_on},
          (k >= 4) ? 13'h1FFF : 13'h0000);
    end
  endtask

  initial begin
    int t_f1, t_r1, t_f2, t_tk1, t_tk2, t_vf1, t_vr1, t_vf2;
    logic [9:0] lat_cols[5];

    vecs[0]  = '{8'hAE, 10'd10,  4'hB, 4'h6, 4'hA, 1'b1, 1'b1};
    vecs[1]  = '{8'hFF, 10'd20,  4'hF, 4'hF, 4'hF, 1'b1, 1'b1};
    vecs[2]  = '{8'h00, 10'd30,  4'h0, 4'h0, 4'h0, 1'b1, 1'b1};
    vecs[3]  = '{8'hE0, 10'd100, 4'hF, 4'h0, 4'h0, 1'b1, 1'b1};
    vecs[4]  = '{8'h1C, 10'd200, 4'h0, 4'hF, 4'h0, 1'b1, 1'b1};
    vecs[5]  = '{8'h03, 10'd300, 4'h0, 4'h0, 4'hF, 1'b1, 1'b1};
    vecs[6]  = '{8'h49, 10'd400, 4'h4, 4'h4, 4'h5, 1'b1, 1'b1};
    vecs[7]  = '{8'h92, 10'd639, 4'h9, 4'h9, 4'hA, 1'b1, 1'b1};
    vecs[8]  = '{8'hAE, 10'd640, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1};
    vecs[9]  = '{8'hFF, 10'd655, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1};
    vecs[10] = '{8'hFF, 10'd656, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0};
    vecs[11] = '{8'hFF, 10'd751, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0};
    vecs[12] = '{8'hFF, 10'd752, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1};
    vecs[13] = '{8'hFF, 10'd799, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1};
    lat_cols = '{10'd50, 10'd51, 10'd52, 10'd300, 10'd639};

    reset    = 1'b1;
    wp_const = 8'hFF;
    lat_mode = 1'b0;
    #22;
    check_reset_vals("reset");
    #1 reset = 1'b0;
    check_startup("startup");

    foreach (vecs[i]) begin
      wait_col(vecs[i].col);
      wp_const = vecs[i].wp;
      repeat (4) step();
      chk($sformatf("vec%0d_red", i), ifa.red, vecs[i].r);
      chk($sformatf("vec%0d_green", i), ifa.green, vecs[i].g);
      chk($sformatf("vec%0d_blue", i), ifa.blue, vecs[i].b);
      chk($sformatf("vec%0d_von", i), ifa.video_on, vecs[i].von);
      chk($sformatf("vec%0d_hsync", i), ifa.horiz_sync, vecs[i].hs);
      chk($sformatf("vec%0d_vsync", i), ifa.vert_sync, 1'b1);
    end

    wait_hs(1'b0, t_f1);
    chk("hsync_fall_col", ifa.pixel_column, 10'd657);
    wait_hs(1'b1, t_r1);
    wait_hs(1'b0, t_f2);
    chk("hsync_low_width", t_r1 - t_f1, 384);
    chk("hsync_period", t_f2 - t_f1, 3200);

    lat_mode = 1'b1;
    foreach (lat_cols[i]) begin
      wait_col(lat_cols[i]);
      repeat (4) step();
      chk($sformatf("latency_col%0d", lat_cols[i]), {ifa.red, ifa.green, ifa.blue},
          map_rgb(resp_f(lat_cols[i])));
    end

    lat_mode = 1'b0;
    wp_const = 8'hFF;
    wait_hs(1'b0, t_f1);
    step();
    step();
    chk("pre_reset_hsync", ifa.horiz_sync, 1'b0);
    #2 reset = 1'b1;
    #1;
    check_reset_vals("midline_reset");
    #20;
    chk("held_reset_col", ifa.pixel_column, 10'd0);
    reset = 1'b0;
    check_startup("restart");

    wait_tick_s(t_tk1);
    step();
    chk("tick_width", ifs.frame_tick, 1'b0);
    wait_tick_s(t_tk2);
    chk("tick_period", t_tk2 - t_tk1, 640);

    wait_vs_s(1'b0, t_vf1);
    wait_vs_s(1'b1, t_vr1);
    wait_vs_s(1'b0, t_vf2);
    chk("vsync_low_width", t_vr1 - t_vf1, 128);
    chk("vsync_period", t_vf2 - t_vf1, 640);

    wait_pos_s(10'd5, 10'd2);
    repeat (4) step();
    chk("row_blank_rgb", {ifs.red, ifs.green, ifs.blue}, 12'h000);
    chk("row_blank_von", ifs.video_on, 1'b0);
    wait_pos_s(10'd2, 10'd2);
    repeat (4) step();
    chk("row_vis_rgb", {ifs.red, ifs.green, ifs.blue}, 12'hFFF);
    chk("row_vis_von", ifs.video_on, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
